// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  sel
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a programmable
// baud divisor. Registers: DATA (+0), STATUS (+4), DIV (+8), reserved (+12).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q;
  logic [15:0]     div_q;
  logic [1:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [1:0] off;
  logic       wr_data, wr_status, wr_div;
  logic       full, empty, busy, push, pop;
  logic       unused_bits;

  assign off       = bus.addr[3:2];
  assign bus.sel   = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr_data   = bus.we && bus.sel && (off == 2'd0);
  assign wr_status = bus.we && bus.sel && (off == 2'd1);
  assign wr_div    = bus.we && bus.sel && (off == 2'd2);

  assign full  = (count_q == Full);
  assign empty = (count_q == '0);
  assign busy  = (state_q != StIdle);
  // Full is judged before any same-cycle pop, so a write to a full FIFO drops.
  assign push  = wr_data && !full;
  assign pop   = (state_q == StIdle) && !empty;

  assign tx  = tx_q;
  assign irq = empty && !busy;

  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

  // Register read mux; purely a function of address and current state.
  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (off)
        2'd1:    bus.rdata = {28'd0, ovf_q, empty, busy, full};
        2'd2:    bus.rdata = {16'd0, div_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wdata[7:0];
  end

  // FIFO pointers, count, sticky overflow and divisor register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_data && full) begin
        ovf_q <= 1'b1;
      end else if (wr_status && bus.wdata[3]) begin
        ovf_q <= 1'b0;
      end
      if (wr_div) div_q <= (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
    end
  end

  // Serialiser next state; the bit period reloads from DIV at every boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StStart;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = div_q;
        end
      end
      StStart: begin
        if (cnt_q == 16'd1) begin
          state_d = StData;
          cnt_d   = div_q;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == 16'd1) begin
          cnt_d = div_q;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        if (cnt_q == 16'd1) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  // Line level decoded from the next state so tx is a glitch-free flop output.
  always_comb begin
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser state; reset forces the line high even mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd1;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, framing, FIFO overflow,
// back-to-back frames, mid-frame divisor change and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] Base     = 32'h0000_0100;
  localparam logic [31:0] AddrData = Base + 32'h0;
  localparam logic [31:0] AddrStat = Base + 32'h4;
  localparam logic [31:0] AddrDiv  = Base + 32'h8;
  localparam logic [31:0] AddrRsv  = Base + 32'hC;

  logic clk;
  logic rst;
  logic tx;
  logic irq;
  int   checks;
  int   failures;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR (Base),
    .DEPTH     (4),
    .DIV_RESET (16'd868)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  // Expected line level for frame slot k (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Receives one frame, sampling near mid-bit; ok is low on timeout or bad stop.
  task automatic rx_frame(input int div, output logic [7:0] b, output logic ok);
    int waited;
    ok = 1'b0;
    b  = 8'h00;
    waited = 0;
    while (tx !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (tx === 1'b0) begin
      repeat (div / 2) @(negedge clk);
      ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clk);
        b[i] = tx;
      end
      repeat (div) @(negedge clk);
      ok = ok && (tx === 1'b1);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL reset_irq got=%b exp=1", irq); end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    bus_read(AddrStat, d);
    if (d !== 32'h0000_0004) begin failures++; $display("FAIL reset_status got=%h exp=00000004", d); end
    checks++;
    bus_read(AddrDiv, d);
    if (d !== 32'd868) begin failures++; $display("FAIL reset_div got=%0d exp=868", d); end
    checks++;
    bus_read(AddrData, d);
    if (d !== 32'd0) begin failures++; $display("FAIL reset_data_read got=%h exp=0", d); end
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      failures++; $display("FAIL reset_release tx=%b irq=%b exp=1,1", tx, irq);
    end
    checks++;
  endtask

  task automatic test_single_byte;
    logic [7:0] b;
    logic       e;
    b = 8'hA5;
    bus_write(AddrDiv, 32'd4);
    bus_write(AddrData, 32'h0000_00A5);
    if (tx !== 1'b1 || irq !== 1'b0) begin
      failures++; $display("FAIL single_latency tx=%b irq=%b exp=1,0", tx, irq);
    end
    checks++;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      e = frame_bit(b, c / 4);
      if (tx !== e) begin failures++; $display("FAIL single_tx c=%0d got=%b exp=%b", c, tx, e); end
      checks++;
      if (c == 39 && irq !== 1'b0) begin failures++; $display("FAIL single_irq_stop got=%b exp=0", irq); end
      if (c == 39) checks++;
    end
    if (irq !== 1'b1) begin failures++; $display("FAIL single_irq_done got=%b exp=1", irq); end
    checks++;
  endtask

  task automatic test_fill_overflow;
    logic [31:0] d;
    logic [7:0]  rb;
    logic        ok;
    bus_write(AddrDiv, 32'd4);
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (i == 6) begin
            bus_read(AddrStat, d);
            if (d[0] !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", d[0]); end
            checks++;
          end
          bus.we    = 1'b1;
          bus.addr  = AddrData;
          bus.wdata = i;
        end
        @(negedge clk);
        bus.we = 1'b0;
        bus_read(AddrStat, d);
        if (d !== 32'h0000_000B) begin failures++; $display("FAIL fill_status got=%h exp=0000000b", d); end
        checks++;
        bus_write(AddrStat, 32'h0000_0008);
        bus_read(AddrStat, d);
        if (d !== 32'h0000_0003) begin failures++; $display("FAIL fill_ovf_clear got=%h exp=00000003", d); end
        checks++;
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          rx_frame(4, rb, ok);
          if (ok !== 1'b1 || rb !== 8'(k)) begin
            failures++; $display("FAIL fill_rx k=%0d got=%h ok=%b exp=%h", k, rb, ok, 8'(k));
          end
          checks++;
        end
      end
    join
    repeat (6) @(negedge clk);
    if (irq !== 1'b1 || tx !== 1'b1) begin
      failures++; $display("FAIL fill_drain irq=%b tx=%b exp=1,1", irq, tx);
    end
    checks++;
  endtask

  task automatic test_addr_decode;
    logic [31:0] d;
    bus_write(AddrDiv, 32'd5);
    bus_read(AddrDiv, d);
    if (d !== 32'd5) begin failures++; $display("FAIL dec_div got=%0d exp=5", d); end
    checks++;
    bus_read(Base + 32'h10, d);
    if (bus.sel !== 1'b0) begin failures++; $display("FAIL dec_sel_out got=%b exp=0", bus.sel); end
    checks++;
    bus_write(Base + 32'h10, 32'd9);
    bus_read(AddrRsv, d);
    if (bus.sel !== 1'b1) begin failures++; $display("FAIL dec_sel_in got=%b exp=1", bus.sel); end
    checks++;
    bus_write(AddrRsv, 32'd7);
    bus_read(AddrRsv, d);
    if (d !== 32'd0) begin failures++; $display("FAIL dec_rsv_read got=%h exp=0", d); end
    checks++;
    bus_read(AddrDiv, d);
    if (d !== 32'd5) begin failures++; $display("FAIL dec_div_kept got=%0d exp=5", d); end
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      failures++; $display("FAIL dec_no_frame tx=%b irq=%b exp=1,1", tx, irq);
    end
    checks++;
    bus_write(AddrDiv, 32'hFFFF_1234);
    bus_read(AddrDiv, d);
    if (d !== 32'h0000_1234) begin failures++; $display("FAIL dec_div_upper got=%h exp=00001234", d); end
    checks++;
    bus_write(AddrDiv, 32'd0);
    bus_read(AddrDiv, d);
    if (d !== 32'd1) begin failures++; $display("FAIL dec_div_zero got=%0d exp=1", d); end
    checks++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       e;
    b1 = 8'h80;
    b2 = 8'h01;
    bus_write(AddrDiv, 32'd2);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = AddrData; bus.wdata = 32'h80;
    @(negedge clk);
    bus.wdata = 32'h01;
    @(negedge clk);
    bus.we = 1'b0;
    for (int c = 0; c < 42; c++) begin
      if (c < 20)       e = frame_bit(b1, c / 2);
      else if (c == 20) e = 1'b1;
      else              e = frame_bit(b2, (c - 21) / 2);
      if (tx !== e) begin failures++; $display("FAIL b2b_tx c=%0d got=%b exp=%b", c, tx, e); end
      checks++;
      if (c < 41) @(negedge clk);
    end
    if (irq !== 1'b1) begin failures++; $display("FAIL b2b_irq got=%b exp=1", irq); end
    checks++;
  endtask

  task automatic test_mid_frame;
    logic [31:0] d;
    logic        e;
    bus_write(AddrDiv, 32'd8);
    bus_write(AddrData, 32'h0000_00FF);
    for (int c = 0; c < 51; c++) begin
      @(negedge clk);
      e = (c < 8) ? 1'b0 : 1'b1;
      if (tx !== e) begin failures++; $display("FAIL mid_tx c=%0d got=%b exp=%b", c, tx, e); end
      checks++;
      if (c == 49 && irq !== 1'b0) begin failures++; $display("FAIL mid_irq_stop got=%b exp=0", irq); end
      if (c == 49) checks++;
      if (c == 50 && irq !== 1'b1) begin failures++; $display("FAIL mid_irq_idle got=%b exp=1", irq); end
      if (c == 50) checks++;
      if (c == 34) begin
        bus.we = 1'b1; bus.addr = AddrDiv; bus.wdata = 32'd2;
      end
      if (c == 35) bus.we = 1'b0;
    end
    bus_write(AddrData, 32'h0000_0000);
    bus_write(AddrData, 32'h0000_0055);
    repeat (5) @(negedge clk);
    if (tx !== 1'b0) begin failures++; $display("FAIL rst_pre_tx got=%b exp=0", tx); end
    checks++;
    #2;
    rst = 1'b0;
    #1;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      failures++; $display("FAIL rst_mid tx=%b irq=%b exp=1,1", tx, irq);
    end
    checks++;
    bus_read(AddrStat, d);
    if (d !== 32'h0000_0004) begin failures++; $display("FAIL rst_mid_status got=%h exp=00000004", d); end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    bus_read(AddrDiv, d);
    if (d !== 32'd868) begin failures++; $display("FAIL rst_mid_div got=%0d exp=868", d); end
    checks++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) begin failures++; $display("FAIL rst_flush c=%0d got=%b exp=1", c, tx); end
      checks++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_addr_decode();
    test_back_to_back();
    test_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
